// File: rtl/riscv_pkg.sv
// Shared encodings for the memory stage: funct3 access types, exception causes,
// FSM states and the data-memory request payload.
package riscv_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'b00,
    EXC_MISALIGN = 2'b01,
    EXC_TIMEOUT  = 2'b10,
    EXC_ILLEGAL  = 2'b11
  } exc_cause_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } dmem_req_t;

  // Unsigned load variants have no store counterpart.
  function automatic logic f3_legal(input logic [2:0] f3, input logic store);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering: store data replication/strobes and load
// byte/halfword extraction with sign or zero extension.
module mem_align
  import riscv_pkg::*;
(
  input  logic [2:0]        st_funct3,
  input  logic [1:0]        st_off,
  input  logic [DATA_W-1:0] st_data,
  output logic [DATA_W-1:0] st_wdata,
  output logic [STRB_W-1:0] st_wstrb,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_off,
  input  logic [DATA_W-1:0] ld_rdata,
  output logic [DATA_W-1:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_wdata = st_data;
    st_wstrb = 4'b1111;
    case (st_funct3)
      F3_B: begin
        st_wdata = {4{st_data[7:0]}};
        st_wstrb = 4'b0001 << st_off;
      end
      F3_H: begin
        st_wdata = {2{st_data[15:0]}};
        st_wstrb = st_off[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = 8'h00;
    case (ld_off)
      2'd0: ld_byte = ld_rdata[7:0];
      2'd1: ld_byte = ld_rdata[15:8];
      2'd2: ld_byte = ld_rdata[23:16];
      2'd3: ld_byte = ld_rdata[31:24];
      default: ;
    endcase
    ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];

    ld_data = ld_rdata;
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'h000000, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'h0000, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues one data-memory access at a time, waits for
// ack with a bounded timeout, and hands results/exceptions to write-back.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic [4:0]      ex_rd,
  input  logic            ex_reg_we,
  input  logic            ex_mem_re,
  input  logic            ex_mem_we,
  input  logic [2:0]      ex_funct3,
  input  logic            flush,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wstrb,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic            wb_reg_we,
  output logic [XLEN-1:0] wb_data,
  output logic            exc_valid,
  output logic [1:0]      exc_cause
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              kill, kill_nx;
  logic              req_v, req_v_nx;
  dmem_req_t         req, req_nx;
  logic [2:0]        p_funct3, p_funct3_nx;
  logic [1:0]        p_off, p_off_nx;
  logic [4:0]        p_rd, p_rd_nx;
  logic              p_reg_we, p_reg_we_nx;
  logic              wb_valid_nx, wb_reg_we_nx, exc_valid_nx;
  logic [4:0]        wb_rd_nx;
  logic [DATA_W-1:0] wb_data_nx;
  exc_cause_t        exc_cause_q, exc_cause_nx;

  logic              accept, is_mem, is_st, bad_f3, misal, kill_eff;
  logic [DATA_W-1:0] st_wdata, ld_data;
  logic [STRB_W-1:0] st_wstrb;

  mem_align u_align (
    .st_funct3 (ex_funct3),
    .st_off    (ex_alu_result[1:0]),
    .st_data   (ex_rs2_data),
    .st_wdata  (st_wdata),
    .st_wstrb  (st_wstrb),
    .ld_funct3 (p_funct3),
    .ld_off    (p_off),
    .ld_rdata  (dmem_rdata),
    .ld_data   (ld_data)
  );

  assign ex_ready   = (state == ST_IDLE);
  assign dmem_req   = req_v;
  assign dmem_we    = req.we;
  assign dmem_addr  = req.addr;
  assign dmem_wdata = req.wdata;
  assign dmem_wstrb = req.wstrb;
  assign exc_cause  = exc_cause_q;

  assign accept   = ex_valid && ex_ready && !flush;
  assign is_mem   = ex_mem_re || ex_mem_we;
  assign is_st    = ex_mem_we;
  assign bad_f3   = !f3_legal(ex_funct3, is_st);
  assign misal    = misaligned(ex_funct3, ex_alu_result[1:0]);
  assign kill_eff = kill || flush;

  // Next-state and registered-output logic.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    kill_nx      = kill;
    req_v_nx     = req_v;
    req_nx       = req;
    p_funct3_nx  = p_funct3;
    p_off_nx     = p_off;
    p_rd_nx      = p_rd;
    p_reg_we_nx  = p_reg_we;
    wb_valid_nx  = 1'b0;
    wb_rd_nx     = wb_rd;
    wb_reg_we_nx = wb_reg_we;
    wb_data_nx   = wb_data;
    exc_valid_nx = 1'b0;
    exc_cause_nx = exc_cause_q;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            wb_valid_nx  = 1'b1;
            wb_rd_nx     = ex_rd;
            wb_reg_we_nx = ex_reg_we;
            wb_data_nx   = ex_alu_result;
          end else if (bad_f3 || misal) begin
            wb_valid_nx  = 1'b1;
            wb_rd_nx     = ex_rd;
            wb_reg_we_nx = 1'b0;
            wb_data_nx   = ex_alu_result;
            exc_valid_nx = 1'b1;
            exc_cause_nx = bad_f3 ? EXC_ILLEGAL : EXC_MISALIGN;
          end else begin
            req_v_nx     = 1'b1;
            req_nx.we    = is_st;
            req_nx.addr  = {ex_alu_result[DATA_W-1:2], 2'b00};
            req_nx.wdata = is_st ? st_wdata : '0;
            req_nx.wstrb = is_st ? st_wstrb : '0;
            p_funct3_nx  = ex_funct3;
            p_off_nx     = ex_alu_result[1:0];
            p_rd_nx      = ex_rd;
            p_reg_we_nx  = ex_reg_we && !is_st;
            cnt_nx       = '0;
            kill_nx      = 1'b0;
            state_nx     = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        kill_nx = kill_eff;
        // Ack has priority over a simultaneous timeout.
        if (dmem_ack) begin
          req_v_nx     = 1'b0;
          kill_nx      = 1'b0;
          state_nx     = ST_IDLE;
          wb_valid_nx  = !kill_eff;
          wb_rd_nx     = p_rd;
          wb_reg_we_nx = p_reg_we && !kill_eff;
          wb_data_nx   = req.we ? '0 : ld_data;
        end else if (cnt == CNT_LAST) begin
          req_v_nx     = 1'b0;
          kill_nx      = 1'b0;
          state_nx     = ST_IDLE;
          wb_valid_nx  = !kill_eff;
          wb_rd_nx     = p_rd;
          wb_reg_we_nx = 1'b0;
          exc_valid_nx = !kill_eff;
          exc_cause_nx = EXC_TIMEOUT;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      kill        <= 1'b0;
      req_v       <= 1'b0;
      req         <= '0;
      p_funct3    <= '0;
      p_off       <= '0;
      p_rd        <= '0;
      p_reg_we    <= 1'b0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_reg_we   <= 1'b0;
      wb_data     <= '0;
      exc_valid   <= 1'b0;
      exc_cause_q <= EXC_NONE;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      kill        <= kill_nx;
      req_v       <= req_v_nx;
      req         <= req_nx;
      p_funct3    <= p_funct3_nx;
      p_off       <= p_off_nx;
      p_rd        <= p_rd_nx;
      p_reg_we    <= p_reg_we_nx;
      wb_valid    <= wb_valid_nx;
      wb_rd       <= wb_rd_nx;
      wb_reg_we   <= wb_reg_we_nx;
      wb_data     <= wb_data_nx;
      exc_valid   <= exc_valid_nx;
      exc_cause_q <= exc_cause_nx;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed scenarios followed by random
// instructions, compared against an arithmetic reference model.
module tb_mem_stage;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_alu_result, ex_rs2_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_we, ex_mem_re, ex_mem_we;
  logic [2:0]  ex_funct3;
  logic        flush;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_we;
  logic [31:0] wb_data;
  logic        exc_valid;
  logic [1:0]  exc_cause;

  mem_stage #(.XLEN(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data),
    .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
    .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we),
    .ex_funct3(ex_funct3), .flush(flush),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_we(wb_reg_we), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_cause(exc_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        exc;
    bit [1:0]  cause;
    bit [4:0]  rd;
    bit        we;
    bit        chk_data;
    bit [31:0] data;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: access size in bytes, 0 when funct3 is not a legal access.
  function automatic int acc_size(input bit st, input bit [2:0] f3);
    case (f3)
      3'd0: return 1;
      3'd1: return 2;
      3'd2: return 4;
      3'd4: return st ? 0 : 1;
      3'd5: return st ? 0 : 2;
      default: return 0;
    endcase
  endfunction

  // 0 = ok, 1 = misaligned, 3 = illegal funct3
  function automatic bit [1:0] classify(input bit st, input bit [2:0] f3, input bit [31:0] a);
    int sz;
    sz = acc_size(st, f3);
    if (sz == 0) return 2'd3;
    if ((a % sz) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit [31:0] load_fmt(input bit [2:0] f3, input bit [31:0] rdata, input bit [31:0] a);
    bit [31:0] v;
    int        sz;
    sz = acc_size(1'b0, f3);
    v  = rdata >> (8 * (a % 4));
    if (sz == 1) v = v % 256;
    if (sz == 2) v = v % 65536;
    if (f3 == 3'd0 && v >= 128)   v = v - 256;
    if (f3 == 3'd1 && v >= 32768) v = v - 65536;
    return v;
  endfunction

  function automatic bit [31:0] store_wdata(input bit [2:0] f3, input bit [31:0] d);
    if (f3 == 3'd0) return (d % 256) * 32'h01010101;
    if (f3 == 3'd1) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  function automatic bit [3:0] store_strb(input bit [2:0] f3, input bit [31:0] a);
    if (f3 == 3'd0) return 4'(1 << (a % 4));
    if (f3 == 3'd1) return ((a % 4) >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  // Monitor: every write-back/exception pulse consumes one expected entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && (wb_valid === 1'b1 || exc_valid === 1'b1)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wb: got wb_valid=%b exc_valid=%b expected no output at %0t",
                 wb_valid, exc_valid, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("mon_wb_valid", 32'(wb_valid), 32'd1);
        chk("mon_wb_rd", 32'(wb_rd), 32'(e.rd));
        chk("mon_wb_reg_we", 32'(wb_reg_we), 32'(e.we));
        chk("mon_exc_valid", 32'(exc_valid), 32'(e.exc));
        if (e.exc) chk("mon_exc_cause", 32'(exc_cause), 32'(e.cause));
        if (e.chk_data) chk("mon_wb_data", wb_data, e.data);
      end
    end
  end

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_mem_re = 1'b0; ex_mem_we = 1'b0; flush = 1'b0;
    dmem_ack = 1'b0;
  endtask

  // Called #1 after a rising edge with the stage in IDLE.
  task automatic alu_op(input bit [4:0] rd, input bit we, input bit [31:0] res, input bit fl);
    ex_valid = 1'b1; ex_mem_re = 1'b0; ex_mem_we = 1'b0;
    ex_alu_result = res; ex_rs2_data = $urandom; ex_rd = rd; ex_reg_we = we;
    ex_funct3 = 3'($urandom); flush = fl;
    dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
    if (!fl) q.push_back('{1'b0, 2'd0, rd, we, 1'b1, res});
    @(posedge clk); #1;
    idle_inputs();
    chk("alu_wb_latency", 32'(wb_valid), 32'(!fl));
    chk("alu_ready", 32'(ex_ready), 32'd1);
  endtask

  // d: WAIT-cycle index of ack (>= TO means none); fk: WAIT-cycle index of flush (-1 none).
  task automatic mem_op(input bit st, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] rs2,
                        input bit [4:0] rd, input bit we, input bit [31:0] rdata,
                        input int d, input int fk, output int req_cycles);
    bit [1:0]  cls;
    bit        acked, killed;
    int        k_end;
    bit [31:0] s_addr, s_wdata;
    bit [3:0]  s_strb;
    bit        s_we;
    cls = classify(st, f3, a);
    req_cycles = 0;
    ex_valid = 1'b1; ex_mem_we = st; ex_mem_re = st ? 1'($urandom_range(0, 1)) : 1'b1;
    ex_alu_result = a; ex_rs2_data = rs2; ex_rd = rd; ex_reg_we = we; ex_funct3 = f3;
    flush = 1'b0; dmem_ack = 1'b0;
    if (cls != 2'd0) begin
      q.push_back('{1'b1, cls, rd, 1'b0, 1'b0, 32'd0});
      @(posedge clk); #1;
      idle_inputs();
      chk("exc_no_req", 32'(dmem_req), 32'd0);
      chk("exc_wb_latency", 32'(wb_valid), 32'd1);
      return;
    end
    acked  = (d < int'(TO));
    k_end  = acked ? d : int'(TO) - 1;
    killed = (fk >= 0) && (fk <= k_end);
    if (!killed) begin
      if (acked) q.push_back('{1'b0, 2'd0, rd, st ? 1'b0 : we, !st, st ? 32'd0 : load_fmt(f3, rdata, a)});
      else       q.push_back('{1'b1, 2'd2, rd, 1'b0, 1'b0, 32'd0});
    end
    @(posedge clk); #1;
    ex_mem_re = 1'b0; ex_mem_we = 1'b0;
    chk("req_issue", 32'(dmem_req), 32'd1);
    chk("req_addr", dmem_addr, a & 32'hFFFF_FFFC);
    chk("req_we", 32'(dmem_we), 32'(st));
    if (st) begin
      chk("req_wdata", dmem_wdata, store_wdata(f3, rs2));
      chk("req_wstrb", 32'(dmem_wstrb), 32'(store_strb(f3, a)));
    end
    chk("wait_not_ready", 32'(ex_ready), 32'd0);
    s_addr = dmem_addr; s_wdata = dmem_wdata; s_strb = dmem_wstrb; s_we = dmem_we;
    for (int k = 0; k < int'(TO); k++) begin
      // A non-memory op waiting on EX must not be taken while busy.
      ex_valid = 1'b1; ex_alu_result = $urandom;
      dmem_ack = (k == d); dmem_rdata = (k == d) ? rdata : $urandom;
      flush = (k == fk);
      if (dmem_req) req_cycles++;
      @(posedge clk); #1;
      dmem_ack = 1'b0; flush = 1'b0; ex_valid = 1'b0;
      if (k == k_end) break;
      chk("hold_req", 32'(dmem_req), 32'd1);
      chk("hold_addr", dmem_addr, s_addr);
      chk("hold_wdata", dmem_wdata, s_wdata);
      chk("hold_wstrb", 32'(dmem_wstrb), 32'(s_strb));
      chk("hold_we", 32'(dmem_we), 32'(s_we));
    end
    chk("done_wb_valid", 32'(wb_valid), 32'(!killed));
    chk("done_req_drop", 32'(dmem_req), 32'd0);
    chk("done_ready", 32'(ex_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int rc;
    rst = 1'b1;
    idle_inputs();
    ex_alu_result = '0; ex_rs2_data = '0; ex_rd = '0; ex_reg_we = 1'b0; ex_funct3 = '0;
    dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_reg_we", 32'(wb_reg_we), 32'd0);
    chk("rst_exc_valid", 32'(exc_valid), 32'd0);
    chk("rst_exc_cause", 32'(exc_cause), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    alu_op(5'd5, 1'b1, 32'h0000_1234, 1'b0);
    mem_op(1'b1, 3'd0, 32'h103, 32'h0000_00AB, 5'd1, 1'b1, 32'd0, 2, -1, rc);
    chk("sb_req_cycles", 32'(rc), 32'd3);
    mem_op(1'b0, 3'd0, 32'h202, 32'd0, 5'd7, 1'b1, 32'h0080_FF00, 1, -1, rc);
    mem_op(1'b0, 3'd4, 32'h202, 32'd0, 5'd8, 1'b1, 32'h0080_FF00, 0, -1, rc);
    mem_op(1'b0, 3'd2, 32'h106, 32'd0, 5'd9, 1'b1, 32'd0, 0, -1, rc);
    mem_op(1'b0, 3'd2, 32'h400, 32'd0, 5'd10, 1'b1, 32'd0, int'(TO) + 5, -1, rc);
    chk("timeout_req_cycles", 32'(rc), 32'(TO));
    mem_op(1'b1, 3'd2, 32'h500, 32'hDEAD_BEEF, 5'd11, 1'b0, 32'd0, 2, 0, rc);
    mem_op(1'b0, 3'd1, 32'h602, 32'd0, 5'd12, 1'b1, 32'h8001_7FFF, int'(TO) - 1, -1, rc);
    mem_op(1'b1, 3'd4, 32'h700, 32'd0, 5'd13, 1'b0, 32'd0, 0, -1, rc);
    mem_op(1'b0, 3'd3, 32'h700, 32'd0, 5'd14, 1'b1, 32'd0, 0, -1, rc);
    mem_op(1'b0, 3'd2, 32'h800, 32'd0, 5'd15, 1'b1, 32'd0, int'(TO) + 1, 3, rc);
    alu_op(5'd16, 1'b1, 32'hCAFE_0000, 1'b1);
    for (int i = 0; i < 6; i++) alu_op(5'(i + 20), 1'(i % 2), 32'(i * 32'h1111), 1'b0);

    // Reset while a load is outstanding: request drops at once, late ack ignored.
    ex_valid = 1'b1; ex_mem_re = 1'b1; ex_mem_we = 1'b0; ex_funct3 = 3'd2;
    ex_alu_result = 32'h300; ex_rd = 5'd3; ex_reg_we = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    chk("pre_rst_req", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_wait_req_drop", 32'(dmem_req), 32'd0);
    chk("rst_wait_ready", 32'(ex_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("late_ack_wb", 32'(wb_valid), 32'd0);
    chk("late_ack_req", 32'(dmem_req), 32'd0);

    for (int i = 0; i < 300; i++) begin
      int        kind, sz, d, fk;
      bit        st;
      bit [2:0]  f3;
      bit [31:0] a;
      kind = $urandom_range(0, 9);
      if (kind < 3) begin
        alu_op(5'($urandom), 1'($urandom), $urandom, ($urandom_range(0, 9) == 0));
      end else begin
        st = 1'($urandom);
        f3 = 3'($urandom);
        a  = $urandom;
        sz = acc_size(st, f3);
        if (sz != 0 && $urandom_range(0, 3) != 0) a = a - (a % sz);
        d  = ($urandom_range(0, 7) == 0) ? int'(TO) + 2 : $urandom_range(0, 5);
        fk = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 4) : -1;
        mem_op(st, f3, a, $urandom, 5'($urandom), 1'($urandom), $urandom, d, fk, rc);
      end
    end

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 Parameter TIMEOUT, default 16, maximum number of WAIT cycles before a bus error; legal range 2..255.
REQ-003 clk  in  1  the single clock; every register samples on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 ex_valid  in  1  EX presents an instruction.
REQ-006 ex_ready  out  1  high when state is IDLE; an instruction is accepted when ex_valid and ex_ready are both high.
REQ-007 ex_alu_result  in  XLEN  ALU result or effective address.
REQ-008 ex_rs2_data  in  XLEN  store source data.
REQ-009 ex_rd  in  5 / ex_reg_we  in  1  destination register and its write enable.
REQ-010 ex_mem_re, ex_mem_we  in  1 each  load or store; both high together is treated as a store.
REQ-011 ex_funct3  in  3  access size and sign.
REQ-012 flush  in  1  squash request.
REQ-013 dmem_req  out  1 / dmem_we  out  1 / dmem_addr  out  XLEN / dmem_wdata  out  XLEN / dmem_wstrb  out  4  data memory request, all registered.
REQ-014 dmem_ack  in  1 / dmem_rdata  in  XLEN  memory completion and read data.
REQ-015 wb_valid  out  1 / wb_rd  out  5 / wb_reg_we  out  1 / wb_data  out  XLEN  registered result to the write-back stage; write-back never stalls.
REQ-016 exc_valid  out  1 / exc_cause  out  2  one-cycle exception pulse; cause 01 misaligned, 10 bus timeout, 11 illegal funct3.

Function
REQ-017 The FSM SHALL have exactly two states: IDLE and WAIT.
REQ-018 Non-memory op accepted in cycle N: wb_valid=1 in N+1; wb_data=ex_alu_result; wb_rd and wb_reg_we copied from EX.
REQ-019 Legal aligned memory op accepted in N: dmem_req=1 from N+1; state moves to WAIT.
REQ-020 In WAIT, dmem_req, dmem_addr, dmem_we, dmem_wdata and dmem_wstrb SHALL be held stable.
REQ-021 dmem_ack high in WAIT cycle M: dmem_req=0 in M+1, wb_valid=1 in M+1, state returns to IDLE in M+1.
REQ-022 For loads, wb_data in M+1 is formatted from dmem_rdata as sampled in M.
REQ-023 For stores, wb_reg_we=0 in M+1.
REQ-024 dmem_ack outside WAIT SHALL be ignored.
REQ-025 dmem_addr SHALL equal ex_alu_result with bits [1:0] forced to 0.
REQ-026 Store lanes: SB replicates the byte into all four lanes, wstrb = 1<<addr[1:0]; SH replicates the halfword, wstrb = 0011 or 1100 by addr[1]; SW uses the full word, wstrb = 1111.
REQ-027 Load data: LB/LH sign-extend and LBU/LHU zero-extend the addressed byte or halfword; LW passes the word.
REQ-028 funct3 encodings: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-029 Misalignment is a halfword with addr[0]=1 or a word with addr[1:0]!=0; on accept the block issues no request, sets wb_valid=1 with wb_reg_we=0, and pulses exc_valid with cause 01, all in N+1.
REQ-030 Any other memory funct3 (including 100/101 on a store): handled as in REQ-029, but with cause 11.
REQ-031 A wait counter SHALL clear on entry to WAIT and increment each WAIT cycle without ack.
REQ-032 If the counter reaches TIMEOUT-1 without ack: dmem_req drops next cycle, wb_valid=1 with wb_reg_we=0, exc_valid with cause 10, state returns to IDLE.
REQ-033 If ack and timeout occur in the same cycle, ack wins.
REQ-034 flush in IDLE: the instruction on EX in that cycle is not accepted, and wb_valid=0 next cycle.
REQ-035 flush in WAIT SHALL NOT cancel the bus access; it sets a sticky kill bit, and on completion wb_valid=0 and exc_valid=0.
REQ-036 The kill bit clears on return to IDLE.
REQ-037 Back-to-back non-memory ops SHALL sustain one instruction per cycle.

Reset
REQ-038 On rst: state=IDLE; dmem_req, wb_valid, wb_reg_we, exc_valid, the kill bit and the wait counter are 0; all data and address registers are 0; exc_cause=00.
REQ-039 rst asserted during WAIT SHALL drop dmem_req immediately; the late dmem_ack is ignored.

Structure
REQ-040 riscv_pkg SHALL hold the funct3 load/store encodings, the exc_cause codes and the FSM state encoding.
REQ-041 A combinational sub-module mem_align SHALL perform store lane/strobe generation and load extraction/extension; the FSM, counter and pipeline registers live in mem_stage.

Verification
REQ-042 ADD result 0x1234 to rd=5 -> next cycle wb_valid=1, wb_rd=5, wb_reg_we=1, wb_data=0x00001234.
REQ-043 SB 0xAB at address 0x103 with ack after 3 cycles -> dmem_addr=0x100, wstrb=1000, wdata=0xABABABAB, held for 3 cycles; wb_reg_we=0.
REQ-044 LB at 0x202, rdata=0x0080FF00 -> wb_data=0xFFFFFF80; repeated as LBU -> wb_data=0x00000080.
REQ-045 LW at 0x106 -> no dmem_req, exc_valid=1 with cause 01 and wb_reg_we=0 in the next cycle.
REQ-046 LW with no ack, TIMEOUT=16 -> dmem_req high for exactly 16 cycles, then exc cause 10, then ex_ready=1.
REQ-047 flush in WAIT, ack 2 cycles later -> the store completes on the bus; wb_valid stays 0.
